// File: rtl/hilo_divider_pkg.sv
// Shared definitions for the HI/LO iterative divider: FSM states and result constants.
package hilo_divider_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PREP = 3'd1,
      CALC = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } div_state_t;

   localparam int          DIV_ITERS     = 32;
   localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/hilo_divider_div_step.sv
// One radix-2 restoring division step: shift {rem,quo} left, subtract the divisor if it fits.
module div_step #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] rem,
   input  logic [DATA_W-1:0] quo,
   input  logic [DATA_W-1:0] divisor,
   output logic [DATA_W-1:0] rem_next,
   output logic [DATA_W-1:0] quo_next
);

   logic [DATA_W:0] rem_sh;
   logic            fits;

   // The shifted remainder needs one extra bit: it can reach 2*divisor-1.
   // NOTE: every output gets a value on every path, so no latch is inferred.
   always_comb begin
      rem_sh   = {rem, quo[DATA_W-1]};
      fits     = (rem_sh >= {1'b0, divisor});
      rem_next = fits ? (rem_sh[DATA_W-1:0] - divisor) : rem_sh[DATA_W-1:0];
      quo_next = {quo[DATA_W-2:0], fits};
   end

endmodule

// File: rtl/hilo_divider.sv
// Multi-cycle DIV/DIVU unit for the pro pipe; writes HI=remainder, LO=quotient and stalls issue while busy.
module hilo_divider
   import hilo_divider_pkg::*;
#(
   parameter int DATA_W    = DIV_ITERS,
   parameter bit ZERO_FAST = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              is_signed,
   input  logic [DATA_W-1:0] dividend,
   input  logic [DATA_W-1:0] divisor,
   input  logic              cancel,
   output logic              busy,
   output logic              done,
   output logic              pro_wHiEn,
   output logic              pro_wLoEn,
   output logic [DATA_W-1:0] pro_wHiData,
   output logic [DATA_W-1:0] pro_wLoData
);

   localparam int              CNT_W    = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

   localparam logic [2:0] S_IDLE = IDLE;
   localparam logic [2:0] S_PREP = PREP;
   localparam logic [2:0] S_CALC = CALC;
   localparam logic [2:0] S_FIX  = FIX;
   localparam logic [2:0] S_DONE = DONE;

   localparam logic [DATA_W-1:0] ZERO_QUOT = DIV_ZERO_QUOT[DATA_W-1:0];

   logic [2:0]        state;
   logic [DATA_W-1:0] a_q, b_q;
   logic              sgn_q;
   logic [DATA_W-1:0] rem_q, quo_q, dvs_q;
   logic              qneg_q, rneg_q, zero_q;
   logic [CNT_W-1:0]  count;
   logic [DATA_W-1:0] hi_q, lo_q;

   logic              a_neg, b_neg;
   logic [DATA_W-1:0] a_abs, b_abs;
   logic [DATA_W-1:0] rem_nx, quo_nx;

   assign a_neg = sgn_q & a_q[DATA_W-1];
   assign b_neg = sgn_q & b_q[DATA_W-1];
   assign a_abs = a_neg ? -a_q : a_q;
   assign b_abs = b_neg ? -b_q : b_q;

   div_step #(.DATA_W(DATA_W)) u_step (
      .rem      (rem_q),
      .quo      (quo_q),
      .divisor  (dvs_q),
      .rem_next (rem_nx),
      .quo_next (quo_nx)
   );

   // cancel outranks everything, including a start arriving in the same IDLE cycle.
   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         a_q    <= '0;
         b_q    <= '0;
         sgn_q  <= 1'b0;
         rem_q  <= '0;
         quo_q  <= '0;
         dvs_q  <= '0;
         qneg_q <= 1'b0;
         rneg_q <= 1'b0;
         zero_q <= 1'b0;
         count  <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
      end else if (cancel) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  a_q   <= dividend;
                  b_q   <= divisor;
                  sgn_q <= is_signed;
                  state <= S_PREP;
               end
            end
            S_PREP: begin
               rem_q  <= '0;
               quo_q  <= a_abs;
               dvs_q  <= b_abs;
               qneg_q <= a_neg ^ b_neg;
               rneg_q <= a_neg;
               zero_q <= (b_q == '0);
               count  <= '0;
               if (ZERO_FAST && (b_q == '0)) begin
                  hi_q  <= a_q;
                  lo_q  <= ZERO_QUOT;
                  state <= S_DONE;
               end else begin
                  state <= S_CALC;
               end
            end
            S_CALC: begin
               rem_q <= rem_nx;
               quo_q <= quo_nx;
               count <= count + CNT_W'(1);
               if (count == LAST_CNT) state <= S_FIX;
            end
            S_FIX: begin
               // Restoring the sign of |a| to the remainder also makes HI equal the raw dividend for x/0.
               hi_q  <= rneg_q ? -rem_q : rem_q;
               lo_q  <= zero_q ? ZERO_QUOT : (qneg_q ? -quo_q : quo_q);
               state <= S_DONE;
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy        = (state != S_IDLE);
   assign done        = (state == S_DONE) && !cancel && !rst;
   assign pro_wHiEn   = done;
   assign pro_wLoEn   = done;
   assign pro_wHiData = hi_q;
   assign pro_wLoData = lo_q;

endmodule

// File: tb/tb_hilo_divider.sv
// Directed-vector bench for hilo_divider: result table plus cancel, reset, busy-start and late-cancel sequences.
module tb_hilo_divider;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst, start, is_signed, cancel;
   logic [W-1:0] dividend, divisor;
   logic         busy, done, pro_wHiEn, pro_wLoEn;
   logic [W-1:0] pro_wHiData, pro_wLoData;

   hilo_divider #(.DATA_W(W), .ZERO_FAST(1'b1)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .is_signed   (is_signed),
      .dividend    (dividend),
      .divisor     (divisor),
      .cancel      (cancel),
      .busy        (busy),
      .done        (done),
      .pro_wHiEn   (pro_wHiEn),
      .pro_wLoEn   (pro_wLoEn),
      .pro_wHiData (pro_wHiData),
      .pro_wLoData (pro_wLoData)
   );

   always #5 clk = ~clk;

   int n_cmp    = 0;
   int n_fail   = 0;
   int en_count = 0;

   // Every write-enable or done seen at a clock edge counts as a write.
   always @(posedge clk) begin
      if (pro_wHiEn || pro_wLoEn || done) en_count <= en_count + 1;
   end

   typedef struct {
      logic         sgn;
      logic [W-1:0] a;
      logic [W-1:0] b;
      int           lat;
      logic [W-1:0] lo;
      logic [W-1:0] hi;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Start an operation in the current cycle T and follow it to the write and the idle cycle after.
   task automatic run_op(input vec_t v, input string name);
      int got;
      int en0;
      got       = -1;
      en0       = en_count;
      is_signed = v.sgn;
      dividend  = v.a;
      divisor   = v.b;
      start     = 1'b1;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (k == 1) begin
            start = 1'b0;
            check({name, " busy@T+1"}, 32'(busy), 32'd1);
         end
         if (got < 0 && done) begin
            got = k;
            check({name, " latency"}, 32'(got), 32'(v.lat));
            check({name, " LO"}, pro_wLoData, v.lo);
            check({name, " HI"}, pro_wHiData, v.hi);
            check({name, " enables"}, {30'd0, pro_wHiEn, pro_wLoEn}, 32'd3);
         end else if (got >= 0) begin
            check({name, " done after"}, 32'(done), 32'd0);
            check({name, " busy after"}, 32'(busy), 32'd0);
            check({name, " write count"}, 32'(en_count - en0), 32'd1);
            break;
         end
      end
      if (got < 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s timeout: no done within 60 cycles", name);
      end
   endtask

   initial begin
      int   en0;
      vec_t v72;

      vecs[0]  = '{1'b0, 32'h0000_0007, 32'h0000_0002, 35, 32'h0000_0003, 32'h0000_0001};
      vecs[1]  = '{1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 35, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
      vecs[2]  = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 35, 32'hFFFF_FFFD, 32'h0000_0001};
      vecs[3]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 35, 32'h8000_0000, 32'h0000_0000};
      vecs[4]  = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 35, 32'hFFFF_FFFF, 32'h0000_0000};
      vecs[5]  = '{1'b0, 32'h1234_5678, 32'h0000_0000,  2, 32'hFFFF_FFFF, 32'h1234_5678};
      vecs[6]  = '{1'b1, 32'hFFFF_FFF9, 32'h0000_0000,  2, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
      vecs[7]  = '{1'b0, 32'h0000_0100, 32'h0000_0007, 35, 32'h0000_0024, 32'h0000_0004};
      vecs[8]  = '{1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 35, 32'h0000_000E, 32'hFFFF_FFFE};
      vecs[9]  = '{1'b0, 32'h0000_0003, 32'hFFFF_FFFF, 35, 32'h0000_0000, 32'h0000_0003};
      vecs[10] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 35, 32'h0FFF_FFFF, 32'h0000_000F};
      vecs[11] = '{1'b1, 32'h8000_0000, 32'h0000_0002, 35, 32'hC000_0000, 32'h0000_0000};
      v72 = vecs[0];

      rst = 1'b1; start = 1'b0; cancel = 1'b0; is_signed = 1'b0;
      dividend = '0; divisor = '0;
      repeat (2) @(negedge clk);
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset enables", {30'd0, pro_wHiEn, pro_wLoEn}, 32'd0);
      check("reset HI data", pro_wHiData, 32'd0);
      check("reset LO data", pro_wLoData, 32'd0);
      rst = 1'b0;

      // Back-to-back: each op starts in the idle cycle right after the previous write.
      for (int i = 0; i < 12; i++) run_op(vecs[i], $sformatf("vec%0d", i));

      // Cancel at T+10, then a fresh op from T+11 must write at T+46.
      en0 = en_count;
      is_signed = 1'b0; dividend = 32'd7; divisor = 32'd2; start = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
         if (k == 10) cancel = 1'b1;
      end
      @(negedge clk);
      cancel = 1'b0;
      check("cancel busy@T+11", 32'(busy), 32'd0);
      check("cancel no write", 32'(en_count - en0), 32'd0);
      run_op(v72, "after_cancel");

      // Reset at T+20 aborts the same way and clears the result registers.
      en0 = en_count;
      is_signed = 1'b1; dividend = 32'hFFFF_FFF9; divisor = 32'd2; start = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
         if (k == 20) rst = 1'b1;
      end
      @(negedge clk);
      rst = 1'b0;
      check("rst busy@T+21", 32'(busy), 32'd0);
      check("rst no write", 32'(en_count - en0), 32'd0);
      check("rst HI cleared", pro_wHiData, 32'd0);
      check("rst LO cleared", pro_wLoData, 32'd0);
      run_op(v72, "after_rst");

      // A second start at T+5 is dropped; only the first result is written at T+35.
      en0 = en_count;
      is_signed = 1'b0; dividend = 32'h100; divisor = 32'd7; start = 1'b1;
      for (int k = 1; k <= 35; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
         if (k == 5) begin
            start = 1'b1; is_signed = 1'b1; dividend = 32'd50; divisor = 32'd3;
         end
         if (k == 6) start = 1'b0;
      end
      check("busy-start done@T+35", 32'(done), 32'd1);
      check("busy-start LO", pro_wLoData, 32'h24);
      check("busy-start HI", pro_wHiData, 32'h4);
      repeat (5) @(negedge clk);
      check("busy-start single write", 32'(en_count - en0), 32'd1);
      check("busy-start idle", 32'(busy), 32'd0);

      // Cancel during the DONE cycle gates the write combinationally.
      en0 = en_count;
      is_signed = 1'b0; dividend = 32'd7; divisor = 32'd2; start = 1'b1;
      for (int k = 1; k <= 35; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
      end
      cancel = 1'b1;
      #1;
      check("late-cancel done", 32'(done), 32'd0);
      check("late-cancel enables", {30'd0, pro_wHiEn, pro_wLoEn}, 32'd0);
      @(negedge clk);
      cancel = 1'b0;
      check("late-cancel busy", 32'(busy), 32'd0);
      check("late-cancel no write", 32'(en_count - en0), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/hilo_divider.md
Name: hilo_divider

Overview:
Iterative radix-2 restoring divider that produces the HI/LO write pair for the register file. It executes DIV/DIVU for the pro pipe and writes HI=remainder and LO=quotient through the register file's wHiEn/wLoEn/wHiData/wLoData write interface. It also drives a busy stall to issue logic. Any MFHI/MFLO that arrives before completion is held off by that stall.

Parameters:
DATA_W, 32, operand/result width
ZERO_FAST, 1, 1 = divide-by-zero bypasses the iteration loop

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  request; sampled only in IDLE
is_signed  in  1  1=DIV, 0=DIVU; captured with start
dividend  in  DATA_W  rs operand; captured with start
divisor  in  DATA_W  rt operand; captured with start
cancel  in  1  pipeline flush/exception; aborts any operation
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse when the result is written
pro_wHiEn  out  1  HI write enable (equals done)
pro_wLoEn  out  1  LO write enable (equals done)
pro_wHiData  out  DATA_W  remainder
pro_wLoData  out  DATA_W  quotient

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state=IDLE. busy, done, wHiEn and wLoEn are 0. wHiData and wLoData are 0. Internal registers are cleared. Reset mid-operation aborts with no write.
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE with start=1 and cancel=0 in cycle T: operands are latched; next state is PREP (cycle T+1).
- PREP (T+1):
  - Registers |dividend| and |divisor| when is_signed=1; raw values otherwise.
  - Records qneg = sign(a) XOR sign(b) and rneg = sign(a) (signed only).
  - If ZERO_FAST=1 and divisor==0, next state is DONE; otherwise next state is CALC with count=0.
- CALC (T+2..T+33): one restoring step per cycle, 32 cycles.
  - Shift {rem,quo} left by 1.
  - If rem >= divisor: rem -= divisor and set quotient bit 0.
  - count increments; on count==DATA_W-1 the next state is FIX.
- FIX (T+34): negate quotient if qneg; negate remainder if rneg. All arithmetic is DATA_W wrap-around.
- DONE (T+35):
  - done=wHiEn=wLoEn=1 for exactly this cycle.
  - wHiData=remainder and wLoData=quotient, valid this cycle.
  - Next state is IDLE.
- Latency: the write occurs 35 cycles after start; busy is high T+1..T+35. Divide-by-zero with ZERO_FAST writes at T+2.
- Divide by zero result: LO=all ones, HI=dividend (raw, unsigned or signed).
- Overflow case: signed 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (natural wrap).
- start while busy: ignored; the operation is not queued.
- cancel in any non-IDLE state: next state is IDLE, with no write that cycle or later.
  - cancel in DONE suppresses done/wHiEn/wLoEn (combinationally gated).
  - start and cancel together in IDLE: cancel wins and nothing is latched.
- Back-to-back: a start in the cycle after DONE (state IDLE) is accepted.
- Outputs other than in DONE: wHiData and wLoData hold their last values; the enables are 0.

Decomposition:
- Shared cpu package:
  - div_state_t enum (IDLE, PREP, CALC, FIX, DONE).
  - DIV_ITERS = 32.
  - DIV_ZERO_QUOT = 32'hFFFF_FFFF.
- Sub-module div_step: combinational single restoring step.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - Unit-testable in isolation.

Test Plan:
- DIVU 7/2, start at T -> busy T+1..T+35; at T+35 done=1, LO=0x00000003, HI=0x00000001; done=0 at T+36.
- DIV 0xFFFFFFF9(-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 7 / 0xFFFFFFFE -> LO=0xFFFFFFFD, HI=0x00000001.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU 0xFFFFFFFF/1 -> LO=0xFFFFFFFF, HI=0.
- DIVU 0x12345678 / 0 (ZERO_FAST=1) -> done at T+2, LO=0xFFFFFFFF, HI=0x12345678.
- Cancel and reset aborts:
  - Start at T, cancel at T+10 -> busy=0 at T+11 and no enable ever asserted; new start at T+11 completes at T+46.
  - rst at T+20 behaves the same way.
- Second start at T+5 while busy with different operands -> ignored; the first result alone is written at T+35. Cancel asserted at T+35 -> no write.
